// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
//   deb_state_e : per-channel FSM state
//   DEF_*       : default channel count and timing (25 MHz clock)
//   cnt_width() : counter width able to hold max_val, plus one spare bit
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEB_HIGH = 2'd1,
    ST_HELD     = 2'd2,
    ST_DEB_LOW  = 2'd3
  } deb_state_e;

  localparam int DEF_NUM_SW          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms
  localparam int DEF_REPEAT_DELAY    = 12500000;  // 500 ms
  localparam int DEF_REPEAT_RATE     = 2500000;   // 100 ms

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/switch_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, IDLE/DEB_HIGH/HELD/DEB_LOW FSM,
// saturating stability counter and auto-repeat counter.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_Switch       : raw asynchronous switch level
//   o_Level        : debounced level
//   o_Press        : 1-cycle pulse on accepted 0->1
//   o_Release      : 1-cycle pulse on accepted 1->0
//   o_Repeat       : 1-cycle auto-repeat pulse while held
module switch_debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat
);

  localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = cnt_width(RPT_MAX);

  // Counters compare against target-1: the edge that would bring the count
  // to its target is the edge that fires, so the pulse is registered there.
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_D_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_R_LAST = RPT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_q;
  logic             sw_s;
  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_last;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_run;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign sw_s     = sync_q[1];
  assign deb_inc  = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
  assign rpt_inc  = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + RPT_W'(1);
  // First pulse waits the full delay, later ones the repeat rate.
  assign rpt_last = rpt_first_q ? RPT_D_LAST : RPT_R_LAST;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], i_Switch};
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    rpt_run     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        if (sw_s) begin
          state_d   = ST_DEB_HIGH;
          deb_cnt_d = DEB_W'(1);
        end
      end
      ST_DEB_HIGH: begin
        if (!sw_s) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d     = ST_HELD;
          deb_cnt_d   = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      ST_HELD: begin
        rpt_run = 1'b1;
        if (!sw_s) begin
          state_d   = ST_DEB_LOW;
          deb_cnt_d = DEB_W'(1);
        end
      end
      ST_DEB_LOW: begin
        if (sw_s) begin
          state_d   = ST_HELD;
          deb_cnt_d = '0;
          rpt_run   = 1'b1;
        end else if (deb_cnt_q >= DEB_LAST) begin
          // Release edge: repeat is not ticked, so it can never coincide.
          state_d     = ST_IDLE;
          deb_cnt_d   = '0;
          level_d     = 1'b0;
          release_d   = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end else begin
          deb_cnt_d = deb_inc;
          rpt_run   = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        deb_cnt_d   = '0;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        level_d     = 1'b0;
      end
    endcase

    if (rpt_run) begin
      if (rpt_cnt_q >= rpt_last) begin
        repeat_d    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_inc;
      end
    end
  end

  assign o_Level   = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Repeat  = repeat_q;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer with press/release/auto-repeat pulses.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_Switch       : NUM_SW raw switch levels
//   o_Level        : debounced levels
//   o_Press        : per-channel accepted-press pulses
//   o_Release      : per-channel accepted-release pulses
//   o_Repeat       : per-channel auto-repeat pulses
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW          = DEF_NUM_SW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Level,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_Repeat
);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    switch_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_Switch (i_Switch[g]),
      .o_Level  (o_Level[g]),
      .o_Press  (o_Press[g]),
      .o_Release(o_Release[g]),
      .o_Repeat (o_Repeat[g])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;
  localparam int NUM_SW = 2;
  localparam int DEB    = 4;
  localparam int RD     = 10;
  localparam int RR     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_SW-1:0] sw = '0;
  logic [NUM_SW-1:0] o_Level, o_Press, o_Release, o_Repeat;

  always #5 clk = ~clk;

  switch_debounce #(
    .NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw),
    .o_Level(o_Level), .o_Press(o_Press), .o_Release(o_Release), .o_Repeat(o_Repeat)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each edge the channel sees the raw level from two edges back;
  // a run of DEB samples disagreeing with the accepted level flips it.
  // While accepted high, elapsed edges since press drive the repeat schedule.
  bit                m_s1 [NUM_SW];
  bit                m_s2 [NUM_SW];
  int                m_run[NUM_SW];
  int                m_t  [NUM_SW];
  logic [NUM_SW-1:0] e_lvl, e_prs, e_rel, e_rep;

  task automatic mdl_reset();
    for (int c = 0; c < NUM_SW; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_run[c] = 0; m_t[c] = 0;
    end
    e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0;
  endtask

  task automatic mdl_step();
    if (!rst_n) begin
      mdl_reset();
      return;
    end
    for (int c = 0; c < NUM_SW; c++) begin
      bit samp;
      samp    = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = sw[c];
      e_prs[c] = 1'b0; e_rel[c] = 1'b0; e_rep[c] = 1'b0;
      if (samp != e_lvl[c]) m_run[c]++;
      else                  m_run[c] = 0;
      if (m_run[c] == DEB) begin
        m_run[c] = 0;
        e_lvl[c] = ~e_lvl[c];
        if (e_lvl[c]) begin
          e_prs[c] = 1'b1;
          m_t[c]   = 0;
        end else begin
          e_rel[c] = 1'b1;
        end
      end else if (e_lvl[c]) begin
        m_t[c]++;
        if (m_t[c] >= RD && ((m_t[c] - RD) % RR) == 0) e_rep[c] = 1'b1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("level",   o_Level,   e_lvl);
    chk("press",   o_Press,   e_prs);
    chk("release", o_Release, e_rel);
    chk("repeat",  o_Repeat,  e_rep);
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_step();
    #1;
    cmp_all();
  endtask

  initial begin
    logic [1:0] ev;
    bit pat [7];
    pat = '{1, 1, 0, 1, 1, 1, 1};

    // Reset state
    mdl_reset();
    #1;
    cmp_all();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // Clean step, auto-repeat, release
    sw = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (k <= 8) chk("step_press", o_Press[0], k == 6);
      if (k >= 6 && k <= 28) chk("step_level", o_Level[0], 1'b1);
      if (k > 6 && k <= 28)
        chk("step_repeat", o_Repeat[0], (k - 6) >= 10 && ((k - 16) % 3) == 0);
      if (k >= 33 && k <= 35) chk("step_release", o_Release[0], k == 34);
      if (k >= 34) begin
        chk("step_level_low", o_Level[0], 1'b0);
        chk("step_no_repeat", o_Repeat[0], 1'b0);
      end
      chk("step_ch1_quiet", {o_Level[1], o_Press[1], o_Release[1], o_Repeat[1]}, 8'h0);
      if (k == 28) sw[0] = 1'b0;
    end

    // Bounce on press
    for (int k = 1; k <= 14; k++) begin
      sw[0] = (k <= 7) ? pat[k-1] : 1'b1;
      cyc();
      chk("bounce_press", o_Press[0], k == 9);
      chk("bounce_release", o_Release[0], 1'b0);
    end
    sw = '0;
    repeat (12) cyc();

    // Simultaneous press on both channels
    sw = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      ev = (k == 6) ? 2'b11 : 2'b00;
      if (k <= 8) chk("simul_press", o_Press, ev);
    end

    // Reset mid-hold, switches still high
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("rst_all_zero", {o_Level, o_Press, o_Release, o_Repeat}, 8'h0);
    cmp_all();
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      ev = (k == 6) ? 2'b11 : 2'b00;
      chk("rst_repress", o_Press, ev);
    end

    // Short glitch on ch1
    sw = '0;
    repeat (14) cyc();
    sw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("glitch_press", o_Press[1], 1'b0);
      chk("glitch_level", o_Level[1], 1'b0);
      if (k == 3) sw[1] = 1'b0;
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      int pr;
      pr = ((i / 500) % 2) ? 3 : 12;
      for (int c = 0; c < NUM_SW; c++)
        if ($urandom_range(0, 99) < pr) sw[c] = ~sw[c];
      cyc();
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        cmp_all();
        cyc();
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
